// File: rtl/dmem_bus_arbiter.sv
// Two-master arbiter for the shared data-memory / timer bus. M0 has fixed priority,
// M1 is protected by a starvation counter; every access runs IDLE -> ACCESS -> DONE.
module dmem_bus_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int CNT_W        = 4
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [1:0]  s_size,
    output logic        s_we,
    output logic        dm_sel,
    output logic        tc0_sel,
    output logic        tc1_sel,
    input  logic [31:0] s_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] starve_cnt;
    logic             winner;
    logic             txn_we;
    logic             txn_err;

    logic        grant_m1;
    logic        any_req;
    logic        req_we;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        hit_dm;
    logic        hit_tc0;
    logic        hit_tc1;
    logic        misaligned;
    logic        req_err;

    assign grant_m1  = m1_req && ((starve_cnt == CNT_W'(STARVE_LIMIT)) || !m0_req);
    assign any_req   = m0_req || m1_req;
    assign req_we    = grant_m1 ? m1_we    : m0_we;
    assign req_size  = grant_m1 ? m1_size  : m0_size;
    assign req_addr  = grant_m1 ? m1_addr  : m0_addr;
    assign req_wdata = grant_m1 ? m1_wdata : m0_wdata;

    assign hit_dm  = req_addr <= 32'h0000_2FFF;
    assign hit_tc0 = (req_addr >= 32'h0000_7F00) && (req_addr <= 32'h0000_7F0B);
    assign hit_tc1 = (req_addr >= 32'h0000_7F10) && (req_addr <= 32'h0000_7F1B);

    assign misaligned = ((req_size == 2'd0) && (req_addr[1:0] != 2'b00)) ||
                        ((req_size == 2'd1) && req_addr[0]);

    // Size code 3 has no meaning on this bus and is rejected like any illegal access.
    assign req_err = !(hit_dm || hit_tc0 || hit_tc1) || misaligned || (req_size == 2'd3) ||
                     ((hit_tc0 || hit_tc1) && (req_size != 2'd0)) ||
                     (req_we && ((req_addr == 32'h0000_7F08) || (req_addr == 32'h0000_7F18)));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            winner     <= 1'b0;
            txn_we     <= 1'b0;
            txn_err    <= 1'b0;
            m0_ack     <= 1'b0;
            m0_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_ack     <= 1'b0;
            m1_err     <= 1'b0;
            m1_rdata   <= '0;
            s_addr     <= '0;
            s_wdata    <= '0;
            s_size     <= '0;
            s_we       <= 1'b0;
            dm_sel     <= 1'b0;
            tc0_sel    <= 1'b0;
            tc1_sel    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register here reads pre-edge values.
            if (!m1_req || ((state == IDLE) && grant_m1)) begin
                starve_cnt <= '0;
            end else if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + CNT_W'(1);
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        winner  <= grant_m1;
                        txn_we  <= req_we;
                        txn_err <= req_err;
                        s_addr  <= req_addr;
                        s_wdata <= req_wdata;
                        s_size  <= req_size;
                        s_we    <= req_we && !req_err;
                        dm_sel  <= hit_dm  && !req_err;
                        tc0_sel <= hit_tc0 && !req_err;
                        tc1_sel <= hit_tc1 && !req_err;
                        state   <= ACCESS;
                    end
                end
                ACCESS: begin
                    s_we    <= 1'b0;
                    dm_sel  <= 1'b0;
                    tc0_sel <= 1'b0;
                    tc1_sel <= 1'b0;
                    if (!txn_we && !txn_err) begin
                        if (winner) m1_rdata <= s_rdata;
                        else        m0_rdata <= s_rdata;
                    end
                    m0_ack <= !winner;
                    m0_err <= !winner && txn_err;
                    m1_ack <= winner;
                    m1_err <= winner && txn_err;
                    state  <= DONE;
                end
                DONE: begin
                    m0_ack <= 1'b0;
                    m0_err <= 1'b0;
                    m1_ack <= 1'b0;
                    m1_err <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/dmem_bus_arbiter.md
Name: dmem_bus_arbiter

Overview:
- Arbitrates the shared data-memory/timer bus between two requesters: M0 (CPU MEM-stage data port, fixed high priority) and M1 (DMA/debug master).
- Decodes addresses into DM (0x0000_0000–0x0000_2FFF), TC0 (0x0000_7F00–0x0000_7F0B) and TC1 (0x0000_7F10–0x0000_7F1B).
- Sequences each access as a fixed 3-state transaction.
- Returns an error acknowledge for illegal accesses instead of driving the bus.

Parameters:
- STARVE_LIMIT, 8: consecutive cycles M1 may wait while pending before it gets priority for one transaction.
- CNT_W, 4: width of the starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- m0_req  in  1  M0 transaction request; held until m0_ack.
- m0_we  in  1  M0 write (1) / read (0).
- m0_size  in  2  0 = word, 1 = half, 2 = byte.
- m0_addr  in  32  M0 byte address.
- m0_wdata  in  32  M0 write data, low-aligned.
- m0_ack  out  1  one-cycle completion pulse.
- m0_err  out  1  valid with m0_ack; 1 = access rejected.
- m0_rdata  out  32  raw addressed word, valid with m0_ack.
- m1_req, m1_we, m1_size, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as the M0 ports, for M1.
- s_addr  out  32  slave byte address.
- s_wdata  out  32  slave write data.
- s_size  out  2  slave access size.
- s_we  out  1  slave write strobe.
- dm_sel  out  1  DM selected.
- tc0_sel  out  1  TC0 selected.
- tc1_sel  out  1  TC1 selected.
- s_rdata  in  32  slave read data, combinational from the selected slave.

Behaviour:
- Reset (asynchronous, reset=0):
  - State IDLE; starvation counter 0; winner register 0.
  - Every output 0, including s_* and *_sel.
  - Reset asserted mid-transaction aborts it immediately: s_we falls without waiting for a clock edge, and no ack is issued.
- State IDLE:
  - At each rising edge, sample m0_req and m1_req.
  - Winner: M1 if m1_req and counter == STARVE_LIMIT; else M0 if m0_req; else M1 if m1_req.
  - If any request is sampled, latch the winner's we/size/addr/wdata, compute the error flag, and go to ACCESS.
- State ACCESS (exactly 1 cycle):
  - If no error: drive s_* from the latched values and assert exactly one of dm_sel/tc0_sel/tc1_sel.
  - s_we = latched we, high for this single cycle only.
  - At the closing edge, register s_rdata into the winner's rdata register (reads only; the register is unchanged on writes). Go to DONE.
  - If error: s_we = 0 and all *_sel = 0; s_addr/s_wdata/s_size are still driven.
- State DONE (exactly 1 cycle):
  - Winner's ack = 1 and err = latched error flag.
  - Winner's rdata is held until its next ack.
  - All *_sel and s_we are 0.
  - Next state is IDLE.
  - The master drops req at the edge ending DONE, so IDLE never re-samples a completed request.
- Timing:
  - Latency from req first sampled to ack is 2 cycles; one transaction per 3 cycles maximum.
  - A req that is still high when sampled in IDLE is a new transaction.
- Error conditions (err = 1, slave untouched):
  - Address outside DM, TC0 and TC1.
  - Word access with addr[1:0] != 0; half access with addr[0] != 0.
  - Half or byte access to TC0/TC1.
  - Write to 0x0000_7F08 or 0x0000_7F18 (read-only COUNT registers).
- Starvation counter:
  - Increments at each edge where m1_req = 1 and M1 is not granted.
  - Saturates at STARVE_LIMIT.
  - Clears when M1 is granted, or in any cycle where m1_req = 0.
- Simultaneous requests:
  - M0 wins unless the counter has reached STARVE_LIMIT.
  - The loser keeps req high and is served in a later arbitration. There is no pre-emption mid-transaction.
- Outside their own DONE cycle, each master's ack and err are 0.

Test Plan:
- Reset, then m0 reads 0x0000_0004 with s_rdata = 0x1234_5678 → dm_sel high in ACCESS only; m0_ack one cycle, 2 cycles after req sampled; m0_rdata = 0x1234_5678; m0_err = 0.
- m0 word write 0x0000_7F04, wdata 0xA5A5_0001 → tc0_sel = 1 and s_we = 1 for exactly one cycle; m0_ack with err = 0.
- Error accesses: m1 word write 0x0000_7F18, m0 half read 0x0000_0003, m0 byte read 0x0000_7F10, m1 read 0x0000_3000 → each gets ack with err = 1; s_we and all *_sel stay 0.
- m0_req and m1_req both held high continuously with STARVE_LIMIT = 8 → M0 granted until the counter saturates at 8; the next arbitration grants M1, then the counter clears and M0 resumes.
- Simultaneous single requests, counter 0 → M0 acked first; M1 acked exactly 3 cycles later.
- Write in progress, reset pulled low mid-ACCESS → s_we and dm_sel drop immediately; no ack; after release, IDLE with counter 0 and all outputs 0.
